dice_roll_ctrl: RTL and testbench
=================================

DICE_ROLL_CTRL -- requirements
Module: dice_roll_ctrl

Interface
REQ-001 Parameter MAX_TRIES, default 8: number of sampling attempts (rejection + retry) before the deterministic fallback is used; legal range 1..15.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 rand_bit  input  1  serial random bit from the LFSR output; a fresh bit is available every cycle.
REQ-005 roll_req  input  1  roll request; level-sampled, accepted only in IDLE.
REQ-006 sides  input  5  die face count; legal range 2..20; captured at acceptance.
REQ-007 result_ack  input  1  consumer acknowledge for the held result.
REQ-008 busy  output  1  high in any state other than IDLE.
REQ-009 result_valid  output  1  high while in HOLD.
REQ-010 result  output  5  roll value, 1..sides; 0 on error.
REQ-011 err  output  1  captured sides value was illegal; valid while result_valid is high.
REQ-012 exhausted  output  1  result came from the fallback path; valid while result_valid is high.

Function
REQ-013 The controller SHALL implement four states: IDLE, COLLECT, CHECK and HOLD.
REQ-014 IDLE, roll_req=1: SHALL latch sides into s_reg, clear sample/bitcnt/tries, and go to COLLECT; busy is high from the next cycle.
REQ-015 At acceptance, if sides<2 or sides>20, the controller SHALL go directly to HOLD with result=0, err=1, exhausted=0.
REQ-016 Bit width K SHALL be derived from s_reg: 2->1; 3..4->2; 5..8->3; 9..16->4; 17..20->5.
REQ-017 COLLECT: each cycle, sample SHALL update to {sample[3:0], rand_bit} and bitcnt SHALL increment; after K bits have been captured, the controller SHALL go to CHECK.
REQ-018 CHECK, sample<s_reg: SHALL set result=sample+1, exhausted=0, and go to HOLD.
REQ-019 CHECK, sample>=s_reg and tries<MAX_TRIES-1: SHALL increment tries, clear sample and bitcnt, and return to COLLECT.
REQ-020 CHECK, sample>=s_reg and tries==MAX_TRIES-1: SHALL set result=sample-s_reg+1 and exhausted=1, and go to HOLD; because sample<2*s_reg, this value is always in 1..s_reg.
REQ-021 CHECK arithmetic SHALL be unsigned, 5-bit, with no truncation loss.
REQ-022 HOLD: result, err and exhausted SHALL remain stable until result_ack=1; on the edge where result_ack=1, the controller SHALL go to IDLE.
REQ-023 result_valid SHALL drop the cycle after ack; a new roll_req is accepted no earlier than the following edge.
REQ-024 roll_req while busy SHALL be ignored and not queued; result_ack outside HOLD SHALL be ignored.
REQ-025 Changes to sides after acceptance SHALL have no effect on the roll in progress.
REQ-026 Latency SHALL be tries_used*(K+1) cycles from the accept edge to result_valid rising; a first-try success takes K+1 cycles.
REQ-027 The controller SHALL never stall the LFSR; bits arriving in IDLE, CHECK or HOLD are discarded.

Reset
REQ-028 reset_n=0 SHALL immediately force: state IDLE, busy=0, result_valid=0, result=0, err=0, exhausted=0, and clear sample/bitcnt/tries/s_reg, including mid-COLLECT or mid-HOLD.
REQ-029 After reset_n deasserts, the first roll_req SHALL be accepted on the next rising edge.

Verification
REQ-030 sides=6 (K=3), rand_bit 1,0,1 -> sample=5, result=6, err=0, exhausted=0; result_valid rises 4 cycles after accept.
REQ-031 sides=6, bits 1,1,1 then 0,1,0 -> first sample 7 rejected, result=3, result_valid 8 cycles after accept, exhausted=0.
REQ-032 MAX_TRIES=8, sides=5, rand_bit held at 1 -> eight rejections of sample 7, then result=3, exhausted=1, result_valid 32 cycles after accept.
REQ-033 sides=21 or sides=1 -> HOLD on the next cycle with result=0, err=1; sides=20 with bits 1,0,0,1,1 -> result=20.
REQ-034 In HOLD with result_ack held low for 10 cycles while toggling roll_req and sides -> result is unchanged and busy=1; ack -> result_valid=0 next cycle, then a new roll is accepted.
REQ-035 reset_n pulsed low mid-COLLECT -> all outputs 0 asynchronously; a following roll behaves as in REQ-030.

Source files
------------

// File: rtl/dice_roll_ctrl.sv
// Dice roll controller: builds a K-bit sample from a serial random bit stream, rejects
// out-of-range samples with bounded retry, and falls back to a modular fold when retries run out.
module dice_roll_ctrl #(
  parameter int unsigned MAX_TRIES = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rand_bit,
  input  logic       roll_req,
  input  logic [4:0] sides,
  input  logic       result_ack,
  output logic       busy,
  output logic       result_valid,
  output logic [4:0] result,
  output logic       err,
  output logic       exhausted
);

  localparam int unsigned SW = 5;
  localparam int unsigned CW = 3;
  localparam int unsigned TW = 4;
  localparam logic [TW-1:0] LAST_TRY = TW'(MAX_TRIES - 1);
  localparam logic [SW-1:0] MIN_SIDES = SW'(2);
  localparam logic [SW-1:0] MAX_SIDES = SW'(20);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    CHECK   = 2'd2,
    HOLD    = 2'd3
  } state_t;

  state_t        state;
  logic [SW-1:0] s_reg;
  logic [SW-1:0] sample;
  logic [CW-1:0] bitcnt;
  logic [TW-1:0] tries;
  logic [CW-1:0] k_bits;
  logic          sides_ok;

  // Smallest bit width whose range covers 0..s_reg-1.
  always_comb begin
    k_bits = CW'(5);
    if (s_reg <= SW'(2))       k_bits = CW'(1);
    else if (s_reg <= SW'(4))  k_bits = CW'(2);
    else if (s_reg <= SW'(8))  k_bits = CW'(3);
    else if (s_reg <= SW'(16)) k_bits = CW'(4);
  end

  assign sides_ok = (sides >= MIN_SIDES) && (sides <= MAX_SIDES);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      s_reg        <= '0;
      sample       <= '0;
      bitcnt       <= '0;
      tries        <= '0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      result       <= '0;
      err          <= 1'b0;
      exhausted    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (roll_req) begin
            s_reg     <= sides;
            sample    <= '0;
            bitcnt    <= '0;
            tries     <= '0;
            busy      <= 1'b1;
            result    <= '0;
            exhausted <= 1'b0;
            if (sides_ok) begin
              err   <= 1'b0;
              state <= COLLECT;
            end else begin
              err          <= 1'b1;
              result_valid <= 1'b1;
              state        <= HOLD;
            end
          end
        end
        COLLECT: begin
          sample <= {sample[SW-2:0], rand_bit};
          bitcnt <= bitcnt + CW'(1);
          if (bitcnt + CW'(1) == k_bits) begin
            state <= CHECK;
          end
        end
        CHECK: begin
          if (sample < s_reg) begin
            result       <= sample + SW'(1);
            exhausted    <= 1'b0;
            result_valid <= 1'b1;
            state        <= HOLD;
          end else if (tries < LAST_TRY) begin
            tries  <= tries + TW'(1);
            sample <= '0;
            bitcnt <= '0;
            state  <= COLLECT;
          end else begin
            // sample < 2*s_reg here, so the fold always lands in 1..s_reg.
            result       <= sample - s_reg + SW'(1);
            exhausted    <= 1'b1;
            result_valid <= 1'b1;
            state        <= HOLD;
          end
        end
        HOLD: begin
          if (result_ack) begin
            busy         <= 1'b0;
            result_valid <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dice_roll_ctrl.sv
// Randomized self-checking bench for dice_roll_ctrl against a roll-level behavioural model.
module tb_dice_roll_ctrl;

  localparam int MAX = 8;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       rand_bit;
  logic       roll_req;
  logic [4:0] sides;
  logic       result_ack;
  logic       busy;
  logic       result_valid;
  logic [4:0] result;
  logic       err;
  logic       exhausted;

  dice_roll_ctrl #(.MAX_TRIES(MAX)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rand_bit     (rand_bit),
    .roll_req     (roll_req),
    .sides        (sides),
    .result_ack   (result_ack),
    .busy         (busy),
    .result_valid (result_valid),
    .result       (result),
    .err          (err),
    .exhausted    (exhausted)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  logic       chk_en = 1'b0;
  logic       exp_busy = 1'b0;
  logic       exp_valid = 1'b0;
  logic [4:0] exp_res = '0;
  logic       exp_err = 1'b0;
  logic       exp_exh = 1'b0;

  // Bits to use for the collected positions of the next roll; empty means random.
  logic       cbits[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_total++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, want, $time);
  endtask

  // Cycle-by-cycle comparison of the DUT against the model's expectations.
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(busy), 32'(exp_busy));
      check("result_valid", 32'(result_valid), 32'(exp_valid));
      if (exp_valid) begin
        check("result", 32'(result), 32'(exp_res));
        check("err", 32'(err), 32'(exp_err));
        check("exhausted", 32'(exhausted), 32'(exp_exh));
      end
    end
  end

  // One complete roll from a negedge in IDLE to the negedge after acknowledge.
  task automatic run_roll(input logic [4:0] sd, input int hold_cyc,
                          output logic [4:0] m_res, output logic m_exh, output logic m_err,
                          output int m_lat);
    int   k;
    int   v;
    logic st[$];
    m_err = (sd < 5'd2) || (sd > 5'd20);
    m_res = '0;
    m_exh = 1'b0;
    m_lat = 0;
    if (!m_err) begin
      k = $clog2(int'(sd));
      for (int i = 0; i < MAX * (k + 1); i++) begin
        if ((i % (k + 1)) < k && cbits.size() > 0) st.push_back(cbits.pop_front());
        else st.push_back(1'($urandom));
      end
      for (int t = 0; t < MAX && m_lat == 0; t++) begin
        v = 0;
        for (int j = 0; j < k; j++) v = v * 2 + int'(st[t * (k + 1) + j]);
        if (v < int'(sd)) begin
          m_res = 5'(v + 1);
          m_lat = (t + 1) * (k + 1);
        end else if (t == MAX - 1) begin
          m_res = 5'(v - int'(sd) + 1);
          m_exh = 1'b1;
          m_lat = MAX * (k + 1);
        end
      end
    end
    cbits.delete();
    exp_res = m_res;
    exp_err = m_err;
    exp_exh = m_exh;
    sides = sd;
    roll_req = 1'b1;
    result_ack = 1'b0;
    rand_bit = 1'($urandom);
    @(posedge clk);
    exp_busy = 1'b1;
    exp_valid = m_err;
    for (int c = 0; c < m_lat; c++) begin
      @(negedge clk);
      rand_bit = st[c];
      roll_req = 1'($urandom);
      sides = 5'($urandom);
      result_ack = 1'($urandom);
      @(posedge clk);
      if (c == m_lat - 1) exp_valid = 1'b1;
    end
    for (int c = 0; c < hold_cyc; c++) begin
      @(negedge clk);
      rand_bit = 1'($urandom);
      roll_req = 1'($urandom);
      sides = 5'($urandom);
      result_ack = 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    result_ack = 1'b1;
    roll_req = 1'($urandom);
    rand_bit = 1'($urandom);
    @(posedge clk);
    exp_busy = 1'b0;
    exp_valid = 1'b0;
    @(negedge clk);
    result_ack = 1'b0;
    roll_req = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_valid"}, 32'(result_valid), 32'd0);
    check({name, "_result"}, 32'(result), 32'd0);
    check({name, "_err"}, 32'(err), 32'd0);
    check({name, "_exh"}, 32'(exhausted), 32'd0);
  endtask

  logic [4:0] r_res;
  logic       r_exh;
  logic       r_err;
  int         r_lat;
  logic [4:0] sd_pick;

  initial begin
    reset_n = 1'b0;
    rand_bit = 1'b0;
    roll_req = 1'b0;
    sides = 5'd6;
    result_ack = 1'b0;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;
    chk_en = 1'b1;

    // sides=6, bits 1,0,1 -> 6 on the first try
    cbits = '{1'b1, 1'b0, 1'b1};
    run_roll(5'd6, 2, r_res, r_exh, r_err, r_lat);
    check("m30_res", 32'(r_res), 32'd6);
    check("m30_lat", 32'(r_lat), 32'd4);
    check("m30_exh", 32'(r_exh), 32'd0);

    // first sample 7 rejected, second sample 2 -> 3
    cbits = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    run_roll(5'd6, 1, r_res, r_exh, r_err, r_lat);
    check("m31_res", 32'(r_res), 32'd3);
    check("m31_lat", 32'(r_lat), 32'd8);

    // every try yields 7 for sides=5 -> fallback 3
    for (int i = 0; i < MAX * 3; i++) cbits.push_back(1'b1);
    run_roll(5'd5, 0, r_res, r_exh, r_err, r_lat);
    check("m32_res", 32'(r_res), 32'd3);
    check("m32_exh", 32'(r_exh), 32'd1);
    check("m32_lat", 32'(r_lat), 32'd32);

    run_roll(5'd21, 1, r_res, r_exh, r_err, r_lat);
    check("m33_err21", 32'(r_err), 32'd1);
    run_roll(5'd1, 0, r_res, r_exh, r_err, r_lat);
    check("m33_err1", 32'(r_err), 32'd1);
    run_roll(5'd0, 0, r_res, r_exh, r_err, r_lat);
    cbits = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    run_roll(5'd20, 0, r_res, r_exh, r_err, r_lat);
    check("m33_res20", 32'(r_res), 32'd20);
    check("m33_lat20", 32'(r_lat), 32'd6);
    cbits = '{1'b0, 1'b0};
    run_roll(5'd2, 0, r_res, r_exh, r_err, r_lat);
    check("m_res2", 32'(r_res), 32'd1);

    // long hold with roll_req/sides toggling
    run_roll(5'd12, 10, r_res, r_exh, r_err, r_lat);

    // reset mid-collect, then the same roll as the first directed case
    sides = 5'd6;
    roll_req = 1'b1;
    @(posedge clk);
    exp_busy = 1'b1;
    @(negedge clk);
    roll_req = 1'b0;
    rand_bit = 1'b1;
    @(negedge clk);
    chk_en = 1'b0;
    #2;
    check("pre_reset_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(negedge clk);
    check_all_zero("held_reset");
    reset_n = 1'b1;
    exp_busy = 1'b0;
    exp_valid = 1'b0;
    chk_en = 1'b1;
    cbits = '{1'b1, 1'b0, 1'b1};
    run_roll(5'd6, 1, r_res, r_exh, r_err, r_lat);

    // randomized rolls
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) == 0) sd_pick = 5'($urandom);
      else sd_pick = 5'($urandom_range(2, 20));
      run_roll(sd_pick, $urandom_range(0, 3), r_res, r_exh, r_err, r_lat);
      repeat ($urandom_range(0, 2)) begin
        rand_bit = 1'($urandom);
        result_ack = 1'($urandom);
        @(negedge clk);
      end
      result_ack = 1'b0;
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
